// File: rtl/pe_simd_pkg.sv
// pe_simd_pkg -- shared encodings and default sizes for the SIMD processing
// element of the systolic array.
//   TYPE_*  : meaning of left_type_i (A operand vs C preload)
//   PREC_*  : meaning of left_prec_i (signed vs unsigned lane arithmetic)
//   state_e : controller states
//   DEF_*   : default parameter values used by pe_simd and pe_simd_lane
package pe_simd_pkg;

    localparam int DEF_SARRAY_W = 8;
    localparam int DEF_LANES    = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_CNT_W    = 8;

    localparam logic TYPE_A = 1'b0;
    localparam logic TYPE_C = 1'b1;

    localparam logic PREC_SIGNED   = 1'b0;
    localparam logic PREC_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pe_simd_lane.sv
// pe_simd_lane -- one MAC lane: extend, multiply, accumulate, preload, clear.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall_i       hold the accumulator
//   mac_i         acc += a*b (product extended per prec_i, wraps at ACC_W)
//   load_i        acc  = top operand extended per prec_i
//   clear_i       acc  = 0 (highest priority)
//   prec_i        PREC_SIGNED / PREC_UNSIGNED
//   a_i, top_i    lane operands (top_i doubles as the C preload value)
//   acc_nxt_o     accumulator value after the coming edge
module pe_simd_lane
    import pe_simd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              mac_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              prec_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] top_i,
    output logic [ACC_W-1:0]  acc_nxt_o
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    top_ext;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                sgn;

    assign sgn = (prec_i == PREC_SIGNED);

    // Operands are widened to the full product width first so the low
    // 2*DATA_W bits are exact for both interpretations.
    assign prod_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i})
                  * $signed({{DATA_W{top_i[DATA_W-1]}}, top_i});
    assign prod_u = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, top_i};

    assign prod_ext = sgn ? {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s}
                          : {{(ACC_W-2*DATA_W){1'b0}}, prod_u};
    assign top_ext  = {{(ACC_W-DATA_W){sgn & top_i[DATA_W-1]}}, top_i};

    always_comb begin
        acc_d = acc_q;
        if (clear_i)     acc_d = '0;
        else if (load_i) acc_d = top_ext;
        else if (mac_i)  acc_d = acc_q + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (rst)           acc_q <= '0;
        else if (!stall_i) acc_q <= acc_d;
    end

    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/pe_simd.sv
// pe_simd -- SIMD MAC processing element for an output-stationary systolic
// array. B flows top->bottom, A/C flow left->right, each with one cycle of
// latency. A storec command drains the column: Y upstream words are passed
// through, then this PE's own accumulators, which are then cleared.
// Ports:
//   clk, rst, stall_i              clock, sync active-high reset, global freeze
//   top_*  (valid,cnt,data)        B operand / C preload value
//   top_storec_i                   drain command
//   top_drain_valid_i/data_i       drain words from the PE above
//   left_* (valid,cnt,type,prec,data)  A operand or C preload tag
//   bot_*, right_*                 registered forwards of top_* / left_*
//   busy_o                         controller not idle
//   err_o                          sticky: ab or storec seen while draining
//
// state    | meaning
// ST_IDLE  | accumulators untouched since last drain/reset
// ST_ACCUM | accumulating or preloaded, waiting for storec
// ST_DRAIN | passing Y upstream words, then emitting own accumulators
module pe_simd
    import pe_simd_pkg::*;
#(
    parameter int X        = 0,
    parameter int Y        = 0,
    parameter int SARRAY_W = DEF_SARRAY_W,
    parameter int LANES    = DEF_LANES,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    top_valid_i,
    input  logic [CNT_W-1:0]        top_cnt_i,
    input  logic [LANES*DATA_W-1:0] top_data_i,
    input  logic                    top_storec_i,
    input  logic                    top_drain_valid_i,
    input  logic [LANES*ACC_W-1:0]  top_drain_data_i,
    input  logic                    left_valid_i,
    input  logic [CNT_W-1:0]        left_cnt_i,
    input  logic                    left_type_i,
    input  logic                    left_prec_i,
    input  logic [LANES*DATA_W-1:0] left_data_i,
    output logic                    bot_valid_o,
    output logic [CNT_W-1:0]        bot_cnt_o,
    output logic [LANES*DATA_W-1:0] bot_data_o,
    output logic                    bot_storec_o,
    output logic                    bot_drain_valid_o,
    output logic [LANES*ACC_W-1:0]  bot_drain_data_o,
    output logic                    right_valid_o,
    output logic [CNT_W-1:0]        right_cnt_o,
    output logic                    right_type_o,
    output logic                    right_prec_o,
    output logic [LANES*DATA_W-1:0] right_data_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam logic [CNT_W-1:0] C_TAG  = CNT_W'(SARRAY_W - X);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        dcnt_q, dcnt_d, beat;
    logic                    err_q, err_d;
    logic                    ab, c_in, c_hit, in_drain, store_go, drain_last;
    logic [LANES*ACC_W-1:0]  acc_nxt;
    logic                    dvld_q, dvld_d;
    logic [LANES*ACC_W-1:0]  ddata_q, ddata_d;

    assign ab         = top_valid_i & left_valid_i & (left_type_i == TYPE_A);
    assign c_in       = left_valid_i & (left_type_i == TYPE_C);
    assign c_hit      = c_in & (left_cnt_i == C_TAG);
    assign in_drain   = (state_q == ST_DRAIN);
    assign store_go   = top_storec_i & ~in_drain;
    // dcnt_q counts DRAIN cycles from 0; the storec cycle itself is beat 0.
    assign beat       = dcnt_q + CNT_W'(1);
    assign drain_last = in_drain & (dcnt_q == Y_LAST);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pe_simd_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .stall_i   (stall_i),
            .mac_i     (ab & ~in_drain),
            .load_i    (c_hit & ~in_drain),
            .clear_i   (drain_last),
            .prec_i    (left_prec_i),
            .a_i       (left_data_i[l*DATA_W +: DATA_W]),
            .top_i     (top_data_i[l*DATA_W +: DATA_W]),
            .acc_nxt_o (acc_nxt[l*ACC_W +: ACC_W])
        );
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (store_go) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end else if (ab | c_hit) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (store_go) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (ab | top_storec_i) err_d = 1'b1;
                if (drain_last) state_d = ST_IDLE;
                else            dcnt_d  = beat;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drain path: outside a drain, words pass straight through. acc_nxt is
    // used for the own-acc beat so an ab in the storec cycle (Y=0) is included.
    always_comb begin
        dvld_d  = top_drain_valid_i;
        ddata_d = top_drain_data_i;
        if (store_go) begin
            dvld_d  = 1'b1;
            ddata_d = (Y == 0) ? acc_nxt : top_drain_data_i;
        end else if (in_drain) begin
            if (drain_last) begin
                dvld_d  = 1'b0;
                ddata_d = '0;
            end else begin
                dvld_d  = 1'b1;
                ddata_d = (beat == Y_LAST) ? acc_nxt : top_drain_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dcnt_q        <= '0;
            err_q         <= 1'b0;
            dvld_q        <= 1'b0;
            ddata_q       <= '0;
            bot_valid_o   <= 1'b0;
            bot_cnt_o     <= '0;
            bot_data_o    <= '0;
            bot_storec_o  <= 1'b0;
            right_valid_o <= 1'b0;
            right_cnt_o   <= '0;
            right_type_o  <= 1'b0;
            right_prec_o  <= 1'b0;
            right_data_o  <= '0;
        end else if (!stall_i) begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            err_q         <= err_d;
            dvld_q        <= dvld_d;
            ddata_q       <= ddata_d;
            bot_valid_o   <= ab;
            bot_cnt_o     <= top_cnt_i;
            bot_data_o    <= top_data_i;
            bot_storec_o  <= top_storec_i;
            right_valid_o <= ab | (c_in & ~c_hit);
            right_cnt_o   <= left_cnt_i;
            right_type_o  <= left_type_i;
            right_prec_o  <= left_prec_i;
            right_data_o  <= left_data_i;
        end
    end

    assign bot_drain_valid_o = dvld_q;
    assign bot_drain_data_o  = ddata_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign err_o             = err_q;

endmodule

// File: tb/tb_pe_simd.sv
// tb_pe_simd -- directed self-checking bench for pe_simd (X=2, Y=2, 4x8-bit
// lanes, 32-bit accumulators). Accumulator contents are observed through
// the drain path.
module tb_pe_simd;

    logic         clk = 1'b0;
    logic         rst, stall_i;
    logic         top_valid_i, top_storec_i, top_drain_valid_i;
    logic [7:0]   top_cnt_i;
    logic [31:0]  top_data_i;
    logic [127:0] top_drain_data_i;
    logic         left_valid_i, left_type_i, left_prec_i;
    logic [7:0]   left_cnt_i;
    logic [31:0]  left_data_i;
    logic         bot_valid_o, bot_storec_o, bot_drain_valid_o;
    logic [7:0]   bot_cnt_o;
    logic [31:0]  bot_data_o;
    logic [127:0] bot_drain_data_o;
    logic         right_valid_o, right_type_o, right_prec_o;
    logic [7:0]   right_cnt_o;
    logic [31:0]  right_data_o;
    logic         busy_o, err_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] w0 = 128'h0a0a0a0a_0b0b0b0b_0c0c0c0c_0d0d0d0d;
    logic [127:0] w1 = 128'h11111111_22222222_33333333_44444444;

    always #5 clk = ~clk;

    pe_simd #(.X(2), .Y(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .top_valid_i       (top_valid_i),
        .top_cnt_i         (top_cnt_i),
        .top_data_i        (top_data_i),
        .top_storec_i      (top_storec_i),
        .top_drain_valid_i (top_drain_valid_i),
        .top_drain_data_i  (top_drain_data_i),
        .left_valid_i      (left_valid_i),
        .left_cnt_i        (left_cnt_i),
        .left_type_i       (left_type_i),
        .left_prec_i       (left_prec_i),
        .left_data_i       (left_data_i),
        .bot_valid_o       (bot_valid_o),
        .bot_cnt_o         (bot_cnt_o),
        .bot_data_o        (bot_data_o),
        .bot_storec_o      (bot_storec_o),
        .bot_drain_valid_o (bot_drain_valid_o),
        .bot_drain_data_o  (bot_drain_data_o),
        .right_valid_o     (right_valid_o),
        .right_cnt_o       (right_cnt_o),
        .right_type_o      (right_type_o),
        .right_prec_o      (right_prec_o),
        .right_data_o      (right_data_o),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] p8(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [127:0] p32(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        top_valid_i       = 1'b0;
        top_cnt_i         = '0;
        top_data_i        = '0;
        top_storec_i      = 1'b0;
        top_drain_valid_i = 1'b0;
        top_drain_data_i  = '0;
        left_valid_i      = 1'b0;
        left_cnt_i        = '0;
        left_type_i       = 1'b0;
        left_prec_i       = 1'b0;
        left_data_i       = '0;
    endtask

    task automatic ab_in(input logic prec, input logic [31:0] a, input logic [31:0] b);
        top_valid_i  = 1'b1;
        left_valid_i = 1'b1;
        left_type_i  = 1'b0;
        left_prec_i  = prec;
        left_data_i  = a;
        top_data_i   = b;
    endtask

    // Full Y=2 drain starting this cycle (T); whatever ab inputs are already
    // applied stay for cycle T only.
    task automatic drain_chk(input string tag, input logic [127:0] exp_acc);
        top_storec_i      = 1'b1;
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w0;
        tick();
        clr_in();
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w1;
        chk({tag, "_b0_valid"}, bot_drain_valid_o, 1);
        chk({tag, "_b0_data"}, bot_drain_data_o, w0);
        chk({tag, "_storec_fwd"}, bot_storec_o, 1);
        tick();
        clr_in();
        chk({tag, "_b1_data"}, bot_drain_data_o, w1);
        chk({tag, "_b1_busy"}, busy_o, 1);
        tick();
        chk({tag, "_own_valid"}, bot_drain_valid_o, 1);
        chk({tag, "_own_acc"}, bot_drain_data_o, exp_acc);
        tick();
        chk({tag, "_end_valid"}, bot_drain_valid_o, 0);
        chk({tag, "_end_busy"}, busy_o, 0);
    endtask

    initial begin
        rst     = 1'b1;
        stall_i = 1'b0;
        clr_in();
        tick();
        tick();
        chk("rst_bot_valid", bot_valid_o, 0);
        chk("rst_right_valid", right_valid_o, 0);
        chk("rst_drain_valid", bot_drain_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;

        // Drain word outside a drain: plain pass-through, FSM stays idle.
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w1;
        tick();
        clr_in();
        chk("idle_drain_valid", bot_drain_valid_o, 1);
        chk("idle_drain_data", bot_drain_data_o, w1);
        chk("idle_busy", busy_o, 0);

        // Signed MAC, 3 beats.
        ab_in(1'b0, p8(1, -2, 3, -4), p8(5, 5, 5, 5));
        top_cnt_i  = 8'd3;
        left_cnt_i = 8'd4;
        tick();
        chk("ab_bot_valid", bot_valid_o, 1);
        chk("ab_bot_data", bot_data_o, p8(5, 5, 5, 5));
        chk("ab_bot_cnt", bot_cnt_o, 3);
        chk("ab_right_valid", right_valid_o, 1);
        chk("ab_right_data", right_data_o, p8(1, -2, 3, -4));
        chk("ab_right_cnt", right_cnt_o, 4);
        chk("ab_busy", busy_o, 1);
        tick();
        tick();
        clr_in();
        tick();
        chk("ab_idle_bot_valid", bot_valid_o, 0);
        drain_chk("sgn_mac", p32(15, -30, 45, -60));

        // Unsigned vs signed interpretation of 0xFF*0xFF.
        ab_in(1'b1, p8(255, 255, 255, 255), p8(255, 255, 255, 255));
        tick();
        clr_in();
        drain_chk("unsigned", p32(65025, 65025, 65025, 65025));
        ab_in(1'b0, p8(255, 255, 255, 255), p8(255, 255, 255, 255));
        tick();
        clr_in();
        drain_chk("signed_ff", p32(1, 1, 1, 1));

        // C preload: tag 6 matches (8-2), tag 5 passes on.
        left_valid_i = 1'b1;
        left_type_i  = 1'b1;
        left_cnt_i   = 8'd6;
        top_data_i   = p8(7, 7, 7, 7);
        tick();
        chk("c_hit_no_right", right_valid_o, 0);
        chk("c_hit_busy", busy_o, 1);
        left_cnt_i = 8'd5;
        top_data_i = p8(9, 9, 9, 9);
        tick();
        clr_in();
        chk("c_miss_right_valid", right_valid_o, 1);
        chk("c_miss_right_cnt", right_cnt_o, 5);
        chk("c_miss_right_type", right_type_o, 1);
        // ab in the storec cycle lands before the snapshot: 7 + 1*1.
        ab_in(1'b0, p8(1, 1, 1, 1), p8(1, 1, 1, 1));
        drain_chk("preload", p32(8, 8, 8, 8));

        // ab during drain is an error and not accumulated; stall mid-drain.
        ab_in(1'b0, p8(2, 2, 2, 2), p8(3, 3, 3, 3));
        tick();
        clr_in();
        top_storec_i      = 1'b1;
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w0;
        tick();
        clr_in();
        chk("err_pre", err_o, 0);
        ab_in(1'b0, p8(1, 1, 1, 1), p8(1, 1, 1, 1));
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w1;
        tick();
        clr_in();
        chk("err_set", err_o, 1);
        chk("err_ab_fwd", right_valid_o, 1);
        chk("err_b1_data", bot_drain_data_o, w1);
        stall_i = 1'b1;
        ab_in(1'b1, p8(4, 4, 4, 4), p8(4, 4, 4, 4));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_drain_data", bot_drain_data_o, w1);
            chk("stall_right_data", right_data_o, p8(1, 1, 1, 1));
        end
        stall_i = 1'b0;
        clr_in();
        tick();
        chk("stall_own_valid", bot_drain_valid_o, 1);
        chk("stall_own_acc", bot_drain_data_o, p32(6, 6, 6, 6));
        tick();
        chk("stall_end_busy", busy_o, 0);
        chk("err_sticky", err_o, 1);

        // Reset mid-drain, with stall also asserted.
        ab_in(1'b0, p8(3, 3, 3, 3), p8(3, 3, 3, 3));
        tick();
        clr_in();
        top_storec_i      = 1'b1;
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w0;
        tick();
        clr_in();
        top_drain_valid_i = 1'b1;
        top_drain_data_i  = w1;
        tick();
        rst     = 1'b1;
        stall_i = 1'b1;
        ab_in(1'b0, p8(1, 1, 1, 1), p8(1, 1, 1, 1));
        tick();
        chk("mid_rst_drain_valid", bot_drain_valid_o, 0);
        chk("mid_rst_drain_data", bot_drain_data_o, 0);
        chk("mid_rst_bot_valid", bot_valid_o, 0);
        chk("mid_rst_right_valid", right_valid_o, 0);
        chk("mid_rst_right_data", right_data_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_err", err_o, 0);
        rst     = 1'b0;
        stall_i = 1'b0;
        clr_in();
        tick();
        drain_chk("post_rst", p32(0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
